// File: rtl/quad_pwm_mixer.sv
// quad_pwm_mixer: CHANNELS quadrature encoders adjust per-channel duty values driving double-buffered PWM outputs.
// Input debouncers are compiled in only when the macro ENC_DEBOUNCE_EN is defined.
module quad_pwm_mixer #(
  parameter int CHANNELS        = 3,
  parameter int PWM_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   enc_a,
  input  logic [CHANNELS-1:0]   enc_b,
  input  logic                  wrap,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  sync,
  output logic [CHANNELS:0]     io_oeb_out,
  output logic [2*CHANNELS-1:0] io_oeb_in
);
  localparam int NBITS = 2 * CHANNELS;
  localparam logic [PWM_WIDTH-1:0] DUTY_MAX = '1;

  logic [NBITS-1:0] meta_q, sample_q;
  logic [NBITS-1:0] accepted;
  logic [CHANNELS-1:0][1:0] prev_q, prev_d;
  logic [CHANNELS-1:0][1:0] step;
  logic [CHANNELS-1:0][PWM_WIDTH-1:0] duty_q, duty_d;
  logic [CHANNELS-1:0][PWM_WIDTH-1:0] shadow_q, shadow_d;
  logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic sync_q, sync_d;

  // Gray position along the forward sequence 00,01,11,10 of {a,b}.
  function automatic logic [1:0] quadPos(input logic a, input logic b);
    return {a, a ^ b};
  endfunction

`ifdef ENC_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [NBITS-1:0] level_q, level_d;
  logic [NBITS-1:0][CW-1:0] dbcnt_q, dbcnt_d;

  always_comb begin
    level_d = level_q;
    dbcnt_d = dbcnt_q;
    for (int i = 0; i < NBITS; i++) begin
      if (sample_q[i] == level_q[i]) begin
        dbcnt_d[i] = '0;
      end else if (dbcnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d[i] = sample_q[i];
        dbcnt_d[i] = '0;
      end else begin
        dbcnt_d[i] = dbcnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      dbcnt_q <= '0;
    end else begin
      level_q <= level_d;
      dbcnt_q <= dbcnt_d;
    end
  end

  assign accepted = level_q;
`else
  // Synchronized levels are accepted as-is; DEBOUNCE_CYCLES has no effect in this build.
  if (DEBOUNCE_CYCLES >= 0) begin : g_no_debounce
    assign accepted = sample_q;
  end
`endif

  always_comb begin
    prev_d = prev_q;
    step   = '0;
    duty_d = duty_q;
    for (int i = 0; i < CHANNELS; i++) begin
      prev_d[i] = {accepted[i], accepted[CHANNELS+i]};
      step[i]   = quadPos(accepted[i], accepted[CHANNELS+i]) - quadPos(prev_q[i][1], prev_q[i][0]);
      // A step of 2 means both phases moved at once: ignored, but prev still follows.
      if (step[i] == 2'd1) begin
        if (wrap || duty_q[i] != DUTY_MAX) duty_d[i] = duty_q[i] + 1'b1;
      end else if (step[i] == 2'd3) begin
        if (wrap || duty_q[i] != '0) duty_d[i] = duty_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    shadow_d = (cnt_q == DUTY_MAX) ? duty_q : shadow_q;
    sync_d   = (cnt_q == '0);
    pwm_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (cnt_q < shadow_q[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= '0;
      sample_q <= '0;
      prev_q   <= '0;
      duty_q   <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      pwm_q    <= '0;
      sync_q   <= 1'b0;
    end else begin
      meta_q   <= {enc_b, enc_a};
      sample_q <= meta_q;
      prev_q   <= prev_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      sync_q   <= sync_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign sync       = sync_q;
  assign io_oeb_out = '0;
  assign io_oeb_in  = '1;
endmodule

// File: tb/tb_quad_pwm_mixer.sv
// Directed bench for quad_pwm_mixer at default parameters; expected latencies follow ENC_DEBOUNCE_EN.
module tb_quad_pwm_mixer;
`ifdef ENC_DEBOUNCE_EN
  localparam int  LATENCY   = 6;
  localparam bit  DEBOUNCED = 1'b1;
`else
  localparam int  LATENCY   = 2;
  localparam bit  DEBOUNCED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] enc_a, enc_b;
  logic       wrap;
  logic [2:0] pwm_out;
  logic       sync;
  logic [3:0] io_oeb_out;
  logic [5:0] io_oeb_in;
  logic [2:0][7:0] dutyObs;

  int checkCount = 0;
  int passCount  = 0;
  int pos [3];
  int h0, h1, h2;
  int dGlitch, dLat, dSim0;
  logic [2:0] expPwm;

  always #5 clk = ~clk;

  quad_pwm_mixer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .wrap      (wrap),
    .pwm_out   (pwm_out),
    .sync      (sync),
    .io_oeb_out(io_oeb_out),
    .io_oeb_in (io_oeb_in)
  );

  assign dutyObs = dut.duty_q;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive all encoder pins from the bench's gray-position model, then hold.
  task automatic applyStimulus(input int holdCycles);
    for (int c = 0; c < 3; c++) begin
      case (pos[c])
        0: begin enc_a[c] = 1'b0; enc_b[c] = 1'b0; end
        1: begin enc_a[c] = 1'b0; enc_b[c] = 1'b1; end
        2: begin enc_a[c] = 1'b1; enc_b[c] = 1'b1; end
        default: begin enc_a[c] = 1'b1; enc_b[c] = 1'b0; end
      endcase
    end
    tick(holdCycles);
  endtask

  task automatic stepChannel(input int ch, input int dir, input int n);
    for (int i = 0; i < n; i++) begin
      pos[ch] = (pos[ch] + dir + 4) % 4;
      applyStimulus(8);
    end
  endtask

  task automatic waitSync();
    int n;
    n = 0;
    while (sync !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    if (sync !== 1'b1) checkOutput("syncTimeout", 32'd0, 32'd1);
  endtask

  task automatic countPeriod(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 256; i++) begin
      c0 += int'(pwm_out[0]);
      c1 += int'(pwm_out[1]);
      c2 += int'(pwm_out[2]);
      tick(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; enc_a = '0; enc_b = '0; wrap = 1'b0;
    for (int c = 0; c < 3; c++) pos[c] = 0;
    tick(3);
    checkOutput("rstPwm", 32'(pwm_out), 32'd0);
    checkOutput("rstSync", 32'(sync), 32'd0);
    checkOutput("oebOut", 32'(io_oeb_out), 32'd0);
    checkOutput("oebIn", 32'(io_oeb_in), 32'h3f);
    reset_n = 1'b1;
    tick(1);
    checkOutput("firstSync", 32'(sync), 32'd1);
    tick(255);
    checkOutput("syncGap", 32'(sync), 32'd0);
    tick(1);
    checkOutput("secondSync", 32'(sync), 32'd1);

    // Ten clockwise detents on channel 1.
    stepChannel(1, 1, 40);
    checkOutput("duty1Up", 32'(dutyObs[1]), 32'd40);
    checkOutput("duty0Idle", 32'(dutyObs[0]), 32'd0);
    checkOutput("duty2Idle", 32'(dutyObs[2]), 32'd0);
    waitSync();
    countPeriod(h0, h1, h2);
    checkOutput("pwm1High40", 32'(h1), 32'd40);
    checkOutput("pwm0Low", 32'(h0), 32'd0);
    checkOutput("pwm2Low", 32'(h2), 32'd0);

    // Saturation at zero, then wrap to max.
    stepChannel(0, -1, 3);
    checkOutput("satLow", 32'(dutyObs[0]), 32'd0);
    wrap = 1'b1;
    stepChannel(0, -1, 1);
    checkOutput("wrapLow", 32'(dutyObs[0]), 32'd255);
    waitSync();
    countPeriod(h0, h1, h2);
    checkOutput("pwm0High255", 32'(h0), 32'd255);

    // Three-cycle glitch on enc_b[0] while saturating at max.
    wrap = 1'b0;
    enc_b[0] = 1'b1;
    tick(3);
    enc_b[0] = 1'b0;
    tick(12);
    dGlitch = DEBOUNCED ? 255 : 254;
    checkOutput("glitch", 32'(dutyObs[0]), 32'(dGlitch));

    // Latency of one stable transition (00->01 = +1) with wrap.
    wrap = 1'b1;
    dLat = (dGlitch + 1) & 255;
    pos[0] = 1;
    applyStimulus(LATENCY);
    checkOutput("latBefore", 32'(dutyObs[0]), 32'(dGlitch));
    tick(1);
    checkOutput("latAt", 32'(dutyObs[0]), 32'(dLat));
    tick(8);

    // Both phases of channel 2 toggle together: no count either way.
    enc_a[2] = 1'b1; enc_b[2] = 1'b1;
    tick(12);
    checkOutput("invalidUp", 32'(dutyObs[2]), 32'd0);
    enc_a[2] = 1'b0; enc_b[2] = 1'b0;
    tick(12);
    checkOutput("invalidDown", 32'(dutyObs[2]), 32'd0);

    // Simultaneous events: ch0 01->11 (+1), ch1 00->01 (+1), ch2 00->10 (-1).
    pos[0] = 2; pos[1] = 1; pos[2] = 3;
    dSim0 = (dLat + 1) & 255;
    applyStimulus(LATENCY);
    checkOutput("simOld0", 32'(dutyObs[0]), 32'(dLat));
    checkOutput("simOld1", 32'(dutyObs[1]), 32'd40);
    checkOutput("simOld2", 32'(dutyObs[2]), 32'd0);
    tick(1);
    checkOutput("simNew0", 32'(dutyObs[0]), 32'(dSim0));
    checkOutput("simNew1", 32'(dutyObs[1]), 32'd41);
    checkOutput("simNew2", 32'(dutyObs[2]), 32'd255);
    tick(8);

    // Reset in mid-run: outputs drop immediately.
    waitSync();
    expPwm = {1'b1, 1'b1, dSim0 != 0};
    checkOutput("pwmBeforeReset", 32'(pwm_out), 32'(expPwm));
    reset_n = 1'b0;
    #1;
    checkOutput("midRstPwm", 32'(pwm_out), 32'd0);
    checkOutput("midRstSync", 32'(sync), 32'd0);
    checkOutput("midRstDuty", 32'(dutyObs[2]), 32'd0);
    checkOutput("midRstOebIn", 32'(io_oeb_in), 32'h3f);
    pos[1] = 0; pos[2] = 0;
    applyStimulus(3);
    reset_n = 1'b1;
    tick(1);
    checkOutput("syncAfterRelease", 32'(sync), 32'd1);
    tick(20);
    checkOutput("restAt11", 32'(dutyObs[0]), 32'd0);

    // Build duty0 = 100, then change it mid-period.
    stepChannel(0, 1, 100);
    checkOutput("duty0Is100", 32'(dutyObs[0]), 32'd100);
    waitSync();
    countPeriod(h0, h1, h2);
    checkOutput("pwm0High100", 32'(h0), 32'd100);
    checkOutput("syncPeriodic", 32'(sync), 32'd1);
    fork
      countPeriod(h0, h1, h2);
      begin
        tick(10);
        stepChannel(0, -1, 4);
      end
    join
    checkOutput("curPeriodKept", 32'(h0), 32'd100);
    checkOutput("duty0Is96", 32'(dutyObs[0]), 32'd96);
    countPeriod(h0, h1, h2);
    checkOutput("nextPeriod96", 32'(h0), 32'd96);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
